// File: rtl/mul_writeback_unit.sv
// Iterative 32x32 shift-add multiplier that writes its 64-bit product back to the
// register file as two consecutive writes: low word to DestReg, high word to DestReg+1.
module mul_writeback_unit #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   input  logic [AW-1:0]    DestReg,
   output logic             Busy,
   output logic             Done,
   output logic [AW-1:0]    WriteRegister,
   output logic [WIDTH-1:0] WriteData,
   output logic             RegWrite
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MUL, WRLO, WRHI} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [2*WIDTH:0]   p_q, p_d;
   logic [AW-1:0]      d_q, d_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic               busy_d, done_d, we_d;
   logic [AW-1:0]      wreg_d, hi_reg;
   logic [WIDTH-1:0]   wdata_d;

   // One multiplier bit per call: the upper half is a WIDTH+1 bit sum so the carry survives the shift.
   function automatic logic [2*WIDTH:0] shift_add(input logic [2*WIDTH:0] p,
                                                  input logic [WIDTH-1:0] a);
      logic [WIDTH:0] upper;
      upper = p[0] ? ({1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, a}) : p[2*WIDTH:WIDTH];
      return {1'b0, upper, p[WIDTH-1:1]};
   endfunction

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (Start) state_d = MUL;
         MUL:     if (cnt_q == LAST) state_d = WRLO;
         WRLO:    state_d = WRHI;
         WRHI:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_d   = a_q;
      p_d   = p_q;
      d_d   = d_q;
      cnt_d = cnt_q;
      if (state_q == IDLE && Start) begin
         a_d   = OpA;
         p_d   = {{(WIDTH+1){1'b0}}, OpB};
         d_d   = DestReg;
         cnt_d = '0;
      end else if (state_q == MUL) begin
         p_d   = shift_add(p_q, a_q);
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         a_q   <= '0;
         p_q   <= '0;
         d_q   <= '0;
         cnt_q <= '0;
      end else begin
         a_q   <= a_d;
         p_q   <= p_d;
         d_q   <= d_d;
         cnt_q <= cnt_d;
      end
   end

   // Outputs are decoded from the upcoming state so they register in step with it.
   always_comb begin
      busy_d  = (state_d != IDLE);
      done_d  = (state_q == WRHI);
      hi_reg  = d_q + AW'(1);
      wreg_d  = '0;
      wdata_d = '0;
      we_d    = 1'b0;
      case (state_d)
         WRLO: begin
            wreg_d  = d_q;
            wdata_d = p_d[WIDTH-1:0];
            we_d    = (d_q != '0);
         end
         WRHI: begin
            wreg_d  = hi_reg;
            wdata_d = p_d[2*WIDTH-1:WIDTH];
            we_d    = (hi_reg != '0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Busy          <= 1'b0;
         Done          <= 1'b0;
         WriteRegister <= '0;
         WriteData     <= '0;
         RegWrite      <= 1'b0;
      end else begin
         Busy          <= busy_d;
         Done          <= done_d;
         WriteRegister <= wreg_d;
         WriteData     <= wdata_d;
         RegWrite      <= we_d;
      end
   end

endmodule
